// File: rtl/de_stage.sv
// de_stage: RV32I decode stage with register file, 2-bit in-flight-writer scoreboard and stall/redirect handling.
// Optional macro DE_WB_BYPASS_EN: a same-cycle WB write to a register's last pending writer clears the hazard without stalling.

`ifndef DBITS
`define DBITS 32
`endif
`ifndef BUS_CANARY_WIDTH
`define BUS_CANARY_WIDTH 4
`endif
`ifndef BUS_CANARY_VALUE
`define BUS_CANARY_VALUE 4'hA
`endif
`ifndef INST_CNT_BITS
`define INST_CNT_BITS 32
`endif
`ifndef OP_BITS
`define OP_BITS 4
`endif
`ifndef FE_latch_WIDTH
`define FE_latch_WIDTH (32 + 2*`DBITS + `INST_CNT_BITS + `BUS_CANARY_WIDTH)
`endif
`ifndef DE_latch_WIDTH
`define DE_latch_WIDTH (1 + 32 + 2*`DBITS + `OP_BITS + 5 + 3*`DBITS + `INST_CNT_BITS + `BUS_CANARY_WIDTH)
`endif

package de_stage_pkg;

    typedef enum logic [`OP_BITS-1:0] {
        OP_NOP    = 4'd0,
        OP_LUI    = 4'd1,
        OP_AUIPC  = 4'd2,
        OP_JAL    = 4'd3,
        OP_JALR   = 4'd4,
        OP_BRANCH = 4'd5,
        OP_LOAD   = 4'd6,
        OP_STORE  = 4'd7,
        OP_OPIMM  = 4'd8,
        OP_OP     = 4'd9
    } op_e;

    typedef struct packed {
        logic [31:0]                    inst;
        logic [`DBITS-1:0]              pc;
        logic [`DBITS-1:0]              pcplus;
        logic [`INST_CNT_BITS-1:0]      inst_count;
        logic [`BUS_CANARY_WIDTH-1:0]   canary;
    } fe_latch_t;

    typedef struct packed {
        logic                           valid;
        logic [31:0]                    inst;
        logic [`DBITS-1:0]              pc;
        logic [`DBITS-1:0]              pcplus;
        op_e                            op;
        logic [4:0]                     rd;
        logic [`DBITS-1:0]              rs1_val;
        logic [`DBITS-1:0]              rs2_val;
        logic [`DBITS-1:0]              imm;
        logic [`INST_CNT_BITS-1:0]      inst_count;
        logic [`BUS_CANARY_WIDTH-1:0]   canary;
    } de_latch_t;

endpackage

module de_stage
    import de_stage_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [`FE_latch_WIDTH-1:0]  from_FE_latch,
    input  logic                        from_AGEX_to_DE,
    input  logic [`DBITS+5:0]           from_WB_to_DE,
    output logic [`DE_latch_WIDTH-1:0]  DE_latch_out,
    output logic                        from_DE_to_FE
);

    fe_latch_t          w_fe;
    logic               w_bubble;
    logic               w_wb_en;
    logic [4:0]         w_wb_reg;
    logic [`DBITS-1:0]  w_wb_val;
    logic               w_wb_wr;
    logic [4:0]         w_rd_f;
    logic [4:0]         w_rs1;
    logic [4:0]         w_rs2;
    logic [4:0]         w_rd;
    logic [`DBITS-1:0]  w_imm_i;
    logic [`DBITS-1:0]  w_imm_s;
    logic [`DBITS-1:0]  w_imm_b;
    logic [`DBITS-1:0]  w_imm_u;
    logic [`DBITS-1:0]  w_imm_j;
    logic [`DBITS-1:0]  w_imm;
    op_e                w_op;
    logic               w_writes;
    logic               w_use1;
    logic               w_use2;
    logic               w_valid;
    logic               w_hit1;
    logic               w_hit2;
    logic               w_busy1;
    logic               w_busy2;
    logic               w_rd_full;
    logic               w_stall;
    logic               w_issue;
    logic               w_canary_bad;
    logic [`DBITS-1:0]  w_rs1_val;
    logic [`DBITS-1:0]  w_rs2_val;
    logic [31:1]        w_inc;
    logic [31:1]        w_dec;
    de_latch_t          w_de_next;

    logic [`DBITS-1:0]  r_rf [32];
    logic [1:0]         r_sb [32];
    de_latch_t          r_de;
    logic               r_canary_err;

    assign w_fe     = fe_latch_t'(from_FE_latch);
    assign w_bubble = (from_FE_latch == '0);
    assign {w_wb_en, w_wb_reg, w_wb_val} = from_WB_to_DE;
    assign w_wb_wr  = w_wb_en && (w_wb_reg != 5'd0);

    assign w_rd_f = w_fe.inst[11:7];
    assign w_rs1  = w_fe.inst[19:15];
    assign w_rs2  = w_fe.inst[24:20];

    assign w_imm_i = {{(`DBITS-12){w_fe.inst[31]}}, w_fe.inst[31:20]};
    assign w_imm_s = {{(`DBITS-12){w_fe.inst[31]}}, w_fe.inst[31:25], w_fe.inst[11:7]};
    assign w_imm_b = {{(`DBITS-13){w_fe.inst[31]}}, w_fe.inst[31], w_fe.inst[7],
                      w_fe.inst[30:25], w_fe.inst[11:8], 1'b0};
    assign w_imm_u = `DBITS'($signed({w_fe.inst[31:12], 12'd0}));
    assign w_imm_j = {{(`DBITS-21){w_fe.inst[31]}}, w_fe.inst[31], w_fe.inst[19:12],
                      w_fe.inst[20], w_fe.inst[30:21], 1'b0};

    always_comb begin
        // NOTE: every signal gets a default first so no decode path can infer a latch.
        w_op     = OP_NOP;
        w_writes = 1'b0;
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_imm    = '0;
        case (w_fe.inst[6:0])
            7'b0110111: begin w_op = OP_LUI;    w_writes = 1'b1; w_imm = w_imm_u; end
            7'b0010111: begin w_op = OP_AUIPC;  w_writes = 1'b1; w_imm = w_imm_u; end
            7'b1101111: begin w_op = OP_JAL;    w_writes = 1'b1; w_imm = w_imm_j; end
            7'b1100111: begin w_op = OP_JALR;   w_writes = 1'b1; w_use1 = 1'b1; w_imm = w_imm_i; end
            7'b1100011: begin w_op = OP_BRANCH; w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_b; end
            7'b0000011: begin w_op = OP_LOAD;   w_writes = 1'b1; w_use1 = 1'b1; w_imm = w_imm_i; end
            7'b0100011: begin w_op = OP_STORE;  w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_s; end
            7'b0010011: begin w_op = OP_OPIMM;  w_writes = 1'b1; w_use1 = 1'b1; w_imm = w_imm_i; end
            7'b0110011: begin w_op = OP_OP;     w_writes = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; end
            default: ;
        endcase
    end

    assign w_valid = (w_op != OP_NOP);
    assign w_rd    = w_writes ? w_rd_f : 5'd0;

    // Write-then-read: a same-cycle WB write is forwarded into the source operands.
    assign w_hit1    = w_wb_wr && (w_wb_reg == w_rs1);
    assign w_hit2    = w_wb_wr && (w_wb_reg == w_rs2);
    assign w_rs1_val = !w_use1 ? '0 : (w_hit1 ? w_wb_val : r_rf[w_rs1]);
    assign w_rs2_val = !w_use2 ? '0 : (w_hit2 ? w_wb_val : r_rf[w_rs2]);

`ifdef DE_WB_BYPASS_EN
    assign w_busy1 = w_use1 && (r_sb[w_rs1] != 2'd0) && !((r_sb[w_rs1] == 2'd1) && w_hit1);
    assign w_busy2 = w_use2 && (r_sb[w_rs2] != 2'd0) && !((r_sb[w_rs2] == 2'd1) && w_hit2);
`else
    assign w_busy1 = w_use1 && (r_sb[w_rs1] != 2'd0);
    assign w_busy2 = w_use2 && (r_sb[w_rs2] != 2'd0);
`endif

    assign w_rd_full     = (w_rd != 5'd0) && (r_sb[w_rd] == 2'd3);
    assign w_stall       = w_valid && (w_busy1 || w_busy2 || w_rd_full);
    assign w_issue       = w_valid && !w_stall && !from_AGEX_to_DE;
    assign from_DE_to_FE = w_stall && !from_AGEX_to_DE && !reset;
    assign w_canary_bad  = !w_bubble && (w_fe.canary != `BUS_CANARY_VALUE);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < 32; i++) begin
            w_inc[i] = w_issue && (w_rd == 5'(i));
            w_dec[i] = w_wb_wr && (w_wb_reg == 5'(i)) && (r_sb[i] != 2'd0);
        end
    end

    always_comb begin
        w_de_next            = '0;
        w_de_next.valid      = 1'b1;
        w_de_next.inst       = w_fe.inst;
        w_de_next.pc         = w_fe.pc;
        w_de_next.pcplus     = w_fe.pcplus;
        w_de_next.op         = w_op;
        w_de_next.rd         = w_rd;
        w_de_next.rs1_val    = w_rs1_val;
        w_de_next.rs2_val    = w_rs2_val;
        w_de_next.imm        = w_imm;
        w_de_next.inst_count = w_fe.inst_count;
        w_de_next.canary     = w_fe.canary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: register file and scoreboard are reset too, so no stale value or dependency survives a reset.
            r_de         <= '0;
            r_canary_err <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
                r_sb[i] <= 2'd0;
            end
        end else begin
            // NOTE: non-blocking updates keep every combinational read above on pre-edge state.
            if (w_wb_wr)
                r_rf[w_wb_reg] <= w_wb_val;
            for (int i = 1; i < 32; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_sb[i] <= r_sb[i] + 2'd1;
                else if (w_dec[i] && !w_inc[i])
                    r_sb[i] <= r_sb[i] - 2'd1;
            end
            r_de <= w_issue ? w_de_next : '0;
            if (w_canary_bad)
                r_canary_err <= 1'b1;
        end
    end

    assign DE_latch_out = r_de;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset)
            assert (!r_canary_err);
    end
`endif

endmodule

// File: tb/tb_de_stage.sv
// tb_de_stage: directed scenarios plus a randomized run of de_stage against a behavioural pipeline model.
// Honours DE_WB_BYPASS_EN the same way the design does, so it checks whichever build it is compiled with.
`timescale 1ns/1ps

module tb_de_stage;
    import de_stage_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [`FE_latch_WIDTH-1:0]  from_FE_latch;
    logic                        from_AGEX_to_DE;
    logic [`DBITS+5:0]           from_WB_to_DE;
    logic [`DE_latch_WIDTH-1:0]  DE_latch_out;
    logic                        from_DE_to_FE;

    fe_latch_t         fe;
    logic              br;
    logic              wb_en;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_val;

    assign from_FE_latch   = fe;
    assign from_AGEX_to_DE = br;
    assign from_WB_to_DE   = {wb_en, wb_reg, wb_val};

    de_stage dut (
        .clk             (clk),
        .reset           (reset),
        .from_FE_latch   (from_FE_latch),
        .from_AGEX_to_DE (from_AGEX_to_DE),
        .from_WB_to_DE   (from_WB_to_DE),
        .DE_latch_out    (DE_latch_out),
        .from_DE_to_FE   (from_DE_to_FE)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_rf [32];
    int          m_cnt [32];
    logic        m_valid;
    logic        m_stall;
    logic        m_issue;
    logic [4:0]  m_rd;
    logic        exp_stall;
    de_latch_t   exp_de;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic fe_latch_t mk_fe(input logic [31:0] inst, input int unsigned n);
        fe_latch_t f;
        if (inst == 32'd0) return '0;
        f.inst       = inst;
        f.pc         = 32'h1000 + 32'(n) * 32'd4;
        f.pcplus     = f.pc + 32'd4;
        f.inst_count = 32'(n);
        f.canary     = `BUS_CANARY_VALUE;
        return f;
    endfunction

    // Instruction format letter: U, J, I, B, S, R, or N for anything not decoded.
    function automatic byte fmt_of(input logic [6:0] opc);
        case (opc)
            7'h37, 7'h17:        return "U";
            7'h6F:               return "J";
            7'h67, 7'h03, 7'h13: return "I";
            7'h63:               return "B";
            7'h23:               return "S";
            7'h33:               return "R";
            default:             return "N";
        endcase
    endfunction

    function automatic op_e op_of(input logic [6:0] opc);
        case (opc)
            7'h37:   return OP_LUI;
            7'h17:   return OP_AUIPC;
            7'h6F:   return OP_JAL;
            7'h67:   return OP_JALR;
            7'h63:   return OP_BRANCH;
            7'h03:   return OP_LOAD;
            7'h23:   return OP_STORE;
            7'h13:   return OP_OPIMM;
            7'h33:   return OP_OP;
            default: return OP_NOP;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] inst, input byte fm);
        logic signed [31:0] s;
        logic [31:0]        top;
        s   = $signed(inst);
        top = 32'(s >>> 31);
        case (fm)
            "I": return 32'(s >>> 20);
            "S": return (32'(s >>> 25) << 5) | 32'(inst[11:7]);
            "B": return (top << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            "U": return inst & 32'hFFFF_F000;
            "J": return (top << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic wb_hit(input logic [4:0] r);
        return wb_en && (wb_reg == r) && (r != 5'd0);
    endfunction

    function automatic logic [31:0] rd_val(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_hit(r)) return wb_val;
        return m_rf[r];
    endfunction

    function automatic logic busy(input logic [4:0] r);
        if (m_cnt[r] == 0) return 1'b0;
`ifdef DE_WB_BYPASS_EN
        if (m_cnt[r] == 1 && wb_hit(r)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]  = 32'd0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_eval();
        logic [31:0] inst;
        byte         fm;
        logic        wr, u1, u2;
        inst    = fe.inst;
        fm      = fmt_of(inst[6:0]);
        wr      = fm inside {"U", "J", "I", "R"};
        u1      = fm inside {"I", "B", "S", "R"};
        u2      = fm inside {"B", "S", "R"};
        m_rd    = wr ? inst[11:7] : 5'd0;
        m_valid = (fe != '0) && (fm != "N");
        m_stall = m_valid && ((u1 && busy(inst[19:15])) || (u2 && busy(inst[24:20])) ||
                              (m_rd != 5'd0 && m_cnt[m_rd] == 3));
        exp_stall = m_stall && !br;
        m_issue   = m_valid && !m_stall && !br;
        exp_de    = '0;
        if (m_issue) begin
            exp_de.valid      = 1'b1;
            exp_de.inst       = inst;
            exp_de.pc         = fe.pc;
            exp_de.pcplus     = fe.pcplus;
            exp_de.op         = op_of(inst[6:0]);
            exp_de.rd         = m_rd;
            exp_de.rs1_val    = u1 ? rd_val(inst[19:15]) : 32'd0;
            exp_de.rs2_val    = u2 ? rd_val(inst[24:20]) : 32'd0;
            exp_de.imm        = imm_of(inst, fm);
            exp_de.inst_count = fe.inst_count;
            exp_de.canary     = fe.canary;
        end
    endtask

    task automatic model_commit();
        if (wb_en && wb_reg != 5'd0) begin
            m_rf[wb_reg] = wb_val;
            if (m_cnt[wb_reg] > 0) m_cnt[wb_reg]--;
        end
        if (m_issue && m_rd != 5'd0) m_cnt[m_rd]++;
    endtask

    // One clock: drive inputs just after an edge, check the stall mid-cycle, check DE_latch after the next edge.
    task automatic step(input fe_latch_t f, input logic b, input logic we, input logic [4:0] wr, input logic [31:0] wv);
        fe = f; br = b; wb_en = we; wb_reg = wr; wb_val = wv;
        #2;
        model_eval();
        check("stall", 256'(from_DE_to_FE), 256'(exp_stall));
        model_commit();
        @(posedge clk);
        #1;
        check("de_latch", 256'(DE_latch_out), 256'(exp_de));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k == 0) return 32'd0;
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        case (k)
            1:       w[6:0] = 7'h7F;
            2:       w[6:0] = 7'h37;
            3:       w[6:0] = 7'h17;
            4:       w[6:0] = 7'h6F;
            5:       w[6:0] = 7'h67;
            6:       w[6:0] = 7'h63;
            7:       w[6:0] = 7'h03;
            8:       w[6:0] = 7'h23;
            9:       w[6:0] = 7'h13;
            default: w[6:0] = 7'h33;
        endcase
        return w;
    endfunction

    initial begin
        de_latch_t   d;
        fe_latch_t   f;
        logic        hold;
        int unsigned seq;

        seq = 0;
        reset = 1'b1; fe = '0; br = 1'b0; wb_en = 1'b0; wb_reg = 5'd0; wb_val = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_de", 256'(DE_latch_out), 256'(0));
        check("reset_stall", 256'(from_DE_to_FE), 256'(0));
        reset = 1'b0;

        // Reset mid-stream: a writer in DE_latch and a stalled dependent at the input are both discarded.
        step(mk_fe(addi(5'd3, 5'd0, 12'd1), ++seq), 1'b0, 1'b0, 5'd0, 32'd0);
        fe = mk_fe(add(5'd4, 5'd3, 5'd3), ++seq);
        #2;
        check("pre_reset_stall", 256'(from_DE_to_FE), 256'(1));
        reset = 1'b1;
        #1;
        check("mid_reset_stall", 256'(from_DE_to_FE), 256'(0));
        check("mid_reset_de", 256'(DE_latch_out), 256'(0));
        check("mid_reset_sb3", 256'(dut.r_sb[3]), 256'(0));
        model_reset();
        @(posedge clk);
        #1;
        fe = '0;
        reset = 1'b0;

        // addi x1,x0,5 issues one cycle later with counter[1]=1.
        step(mk_fe(addi(5'd1, 5'd0, 12'd5), ++seq), 1'b0, 1'b0, 5'd0, 32'd0);
        d = DE_latch_out;
        check("addi_valid", 256'(d.valid), 256'(1));
        check("addi_rd", 256'(d.rd), 256'(1));
        check("addi_rs1", 256'(d.rs1_val), 256'(0));
        check("addi_imm", 256'(d.imm), 256'(5));
        check("addi_sb1", 256'(dut.r_sb[1]), 256'(1));

        // add x2,x1,x1 waits for WB of x1=5.
        f = mk_fe(add(5'd2, 5'd1, 5'd1), ++seq);
        step(f, 1'b0, 1'b0, 5'd0, 32'd0);
        step(f, 1'b0, 1'b1, 5'd1, 32'd5);
`ifndef DE_WB_BYPASS_EN
        step(f, 1'b0, 1'b0, 5'd0, 32'd0);
`endif
        d = DE_latch_out;
        check("add_valid", 256'(d.valid), 256'(1));
        check("add_rs1", 256'(d.rs1_val), 256'(5));
        check("add_rs2", 256'(d.rs2_val), 256'(5));

        // Redirect kills a stalled add; the same-cycle WB decrement still lands.
        step('0, 1'b0, 1'b1, 5'd2, 32'd10);
        step(mk_fe(addi(5'd1, 5'd0, 12'd7), ++seq), 1'b0, 1'b0, 5'd0, 32'd0);
        f = mk_fe(add(5'd2, 5'd1, 5'd1), ++seq);
        step(f, 1'b0, 1'b0, 5'd0, 32'd0);
        step(f, 1'b1, 1'b1, 5'd1, 32'd7);
        d = DE_latch_out;
        check("br_valid", 256'(d.valid), 256'(0));
        check("br_sb2", 256'(dut.r_sb[2]), 256'(0));
        check("br_sb1", 256'(dut.r_sb[1]), 256'(0));

        // Four writers to x3: the fourth waits until a WB decrement.
        for (int i = 0; i < 3; i++)
            step(mk_fe(addi(5'd3, 5'd0, 12'(i + 1)), ++seq), 1'b0, 1'b0, 5'd0, 32'd0);
        check("sb3_full", 256'(dut.r_sb[3]), 256'(3));
        f = mk_fe(addi(5'd3, 5'd0, 12'd4), ++seq);
        step(f, 1'b0, 1'b0, 5'd0, 32'd0);
        step(f, 1'b0, 1'b1, 5'd3, 32'd1);
        step(f, 1'b0, 1'b0, 5'd0, 32'd0);
        check("sb3_refill", 256'(dut.r_sb[3]), 256'(3));
        for (int i = 0; i < 3; i++)
            step('0, 1'b0, 1'b1, 5'd3, 32'(i + 2));

        // x0 ignores writes and always reads 0.
        step('0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step(mk_fe(addi(5'd6, 5'd0, 12'd1), ++seq), 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        d = DE_latch_out;
        check("x0_read", 256'(d.rs1_val), 256'(0));
        check("x0_sb", 256'(dut.r_sb[0]), 256'(0));
        step('0, 1'b0, 1'b1, 5'd6, 32'd1);

        // Same-cycle issue to x4 and WB to x4 leaves counter[4] at 1.
        step(mk_fe(addi(5'd4, 5'd0, 12'd8), ++seq), 1'b0, 1'b0, 5'd0, 32'd0);
        step(mk_fe(addi(5'd4, 5'd0, 12'd9), ++seq), 1'b0, 1'b1, 5'd4, 32'd8);
        check("sb4_net", 256'(dut.r_sb[4]), 256'(1));

        // Randomized run: FE holds a stalled instruction, otherwise presents a fresh one.
        hold = 1'b0;
        f    = '0;
        for (int c = 0; c < 400; c++) begin
            logic b;
            if (!hold) f = mk_fe(rand_inst(), ++seq);
            b = ($urandom_range(0, 9) == 0);
            step(f, b, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            hold = m_stall && !b;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
